// File: rtl/sp_linebuf_sched_pkg.sv
// Shared types and helpers for the salt-and-pepper line-buffer scheduler.
package sp_linebuf_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Rows missing above the window centre.
  function automatic int pad_top_f(input int pos_y, input int half);
    return (pos_y >= half) ? 0 : half - pos_y;
  endfunction

  // Rows missing below the window centre (last real row is h-1).
  function automatic int pad_bot_f(input int pos_y, input int half, input int h);
    int v;
    v = pos_y + half - (h - 1);
    return (v > 0) ? v : 0;
  endfunction

  // Bank rotation, modulo the number of line banks.
  function automatic int next_bank(input int b, input int nb);
    return (b == nb - 1) ? 0 : b + 1;
  endfunction

endpackage

// File: rtl/sp_linebuf_sched_if.sv
// Pixel-in / bank-control-out bundle of the line-buffer scheduler.
interface sp_linebuf_sched_if #(
  parameter int NUM        = 5,
  parameter int DATADEPTH  = 12,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 10
);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int BW = $clog2(NUM-1);
  localparam int PW = $clog2(NUM);

  logic                 vsync, hsync, pix_valid;
  logic [DATADEPTH-1:0] data_i;
  logic [NUM-2:0]       bank_we;
  logic [AW-1:0]        mem_addr;
  logic [DATADEPTH-1:0] mem_wdata;
  logic                 mem_re;
  logic [DATADEPTH-1:0] cur_pix;
  logic [BW-1:0]        oldest_bank;
  logic                 win_valid;
  logic [AW-1:0]        pos_x;
  logic [YW-1:0]        pos_y;
  logic [PW-1:0]        pad_top, pad_bot;
  logic                 frame_done, line_err;

  modport master (
    output vsync, hsync, pix_valid, data_i,
    input  bank_we, mem_addr, mem_wdata, mem_re, cur_pix, oldest_bank, win_valid,
           pos_x, pos_y, pad_top, pad_bot, frame_done, line_err
  );

  modport slave (
    input  vsync, hsync, pix_valid, data_i,
    output bank_we, mem_addr, mem_wdata, mem_re, cur_pix, oldest_bank, win_valid,
           pos_x, pos_y, pad_top, pad_bot, frame_done, line_err
  );
endinterface

// File: rtl/sp_linebuf_sched_pos_counter.sv
// Column/row/bank position tracker: restart, short-line recovery, long-line
// saturation and the sticky line error. Outputs are the position used by the
// access happening this cycle.
module sp_linebuf_sched_pos_counter
  import sp_linebuf_sched_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 10,
  parameter int NB         = 4,
  parameter int HALF       = 2,
  parameter int AW         = 11,
  parameter int YIW        = 4,
  parameter int BW         = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           run_i,
  input  logic           flush_i,
  input  logic           pix_i,
  input  logic           hs_i,
  output logic [AW-1:0]  x_o,
  output logic [YIW-1:0] y_o,
  output logic [BW-1:0]  bank_o,
  output logic           acc_o,
  output logic           wr_o,
  output logic           run_end_o,
  output logic           flush_end_o,
  output logic           err_o
);
  logic [AW-1:0]  x_q, x_d, ex;
  logic [YIW-1:0] y_q, y_d, ey;
  logic [BW-1:0]  b_q, b_d, eb;
  logic           wait_q, wait_d, err_q, err_d;
  logic           acc, wr, short_end, last_col;

  // Effective position of this cycle's access, then advance past it.
  always_comb begin
    ex = x_q; ey = y_q; eb = b_q;
    acc = 1'b0; wr = 1'b0; short_end = 1'b0;
    err_d = err_q; wait_d = wait_q;
    if (start_i) begin
      ex = '0; ey = '0; eb = '0; err_d = 1'b0; wait_d = 1'b0;
      acc = 1'b1; wr = 1'b1;
    end else if (flush_i) begin
      acc = 1'b1;
    end else if (run_i && pix_i) begin
      if (hs_i) begin
        wait_d = 1'b0;
        // hsync before the line completed: close it and start the next one
        if (!wait_q) begin
          err_d = 1'b1; ex = '0; ey = y_q + 1'b1; eb = BW'(next_bank(int'(b_q), NB));
        end
        if (ey < YIW'(IMG_HEIGHT)) begin
          acc = 1'b1; wr = 1'b1;
        end else begin
          short_end = 1'b1;
        end
      end else if (wait_q) begin
        err_d = 1'b1;                 // extra pixel past line end: dropped
      end else begin
        acc = 1'b1; wr = 1'b1;
      end
    end
    last_col = (ex == AW'(IMG_WIDTH-1));
    x_d = ex; y_d = ey; b_d = eb;
    if (acc) begin
      if (last_col) begin
        x_d = '0; y_d = ey + 1'b1; b_d = BW'(next_bank(int'(eb), NB)); wait_d = 1'b1;
      end else begin
        x_d = ex + 1'b1;
      end
    end
  end

  // Position state.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; b_q <= '0; wait_q <= 1'b0; err_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; b_q <= b_d; wait_q <= wait_d; err_q <= err_d;
    end
  end

  assign x_o         = ex;
  assign y_o         = ey;
  assign bank_o      = eb;
  assign acc_o       = acc;
  assign wr_o        = wr;
  assign err_o       = err_q;
  assign run_end_o   = (wr && last_col && ey == YIW'(IMG_HEIGHT-1)) || short_end;
  assign flush_end_o = flush_i && last_col && ey == YIW'(IMG_HEIGHT+HALF-1);
endmodule

// File: rtl/sp_linebuf_sched.sv
// Line-buffer scheduler: bank write rotation, shared SRAM address, and the
// window-valid / pad stream aligned to the one-cycle SRAM read.
module sp_linebuf_sched
  import sp_linebuf_sched_pkg::*;
#(
  parameter int NUM        = 5,
  parameter int DATADEPTH  = 12,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 10
) (
  input  logic               clk,
  input  logic               rst,
  sp_linebuf_sched_if.slave  bus
);
  localparam int HALF = NUM / 2;
  localparam int NB   = NUM - 1;
  localparam int AW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam int YIW  = $clog2(IMG_HEIGHT + HALF + 1);
  localparam int BW   = $clog2(NB);
  localparam int PW   = $clog2(NUM);

  state_t               st_q;
  logic                 start, acc, wr, run_end, flush_end, err, win_d, fd_q;
  logic [AW-1:0]        ex;
  logic [YIW-1:0]       ey, py_full;
  logic [BW-1:0]        eb;
  logic                 win_q;
  logic [AW-1:0]        pos_x_q;
  logic [YW-1:0]        pos_y_q;
  logic [PW-1:0]        pad_top_q, pad_bot_q;
  logic [BW-1:0]        old_q;
  logic [DATADEPTH-1:0] cur_q;

  // A new frame always begins with a valid pixel tagged vsync.
  assign start = bus.vsync & bus.pix_valid;

  sp_linebuf_sched_pos_counter #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .NB(NB), .HALF(HALF),
    .AW(AW), .YIW(YIW), .BW(BW)
  ) u_pos (
    .clk(clk), .rst(rst), .start_i(start), .run_i(st_q == RUN), .flush_i(st_q == FLUSH),
    .pix_i(bus.pix_valid), .hs_i(bus.hsync), .x_o(ex), .y_o(ey), .bank_o(eb),
    .acc_o(acc), .wr_o(wr), .run_end_o(run_end), .flush_end_o(flush_end), .err_o(err)
  );

  assign bus.bank_we   = wr ? (NB'(1) << eb) : '0;
  assign bus.mem_addr  = ex;
  assign bus.mem_re    = acc;
  assign bus.mem_wdata = bus.data_i;
  assign bus.line_err  = err;

  assign win_d   = acc && (ey >= YIW'(HALF));
  assign py_full = ey - YIW'(HALF);

  // Window descriptor registered from the access cycle, zeroed when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= 1'b0; pos_x_q <= '0; pos_y_q <= '0;
      pad_top_q <= '0; pad_bot_q <= '0; old_q <= '0; cur_q <= '0;
    end else begin
      win_q     <= win_d;
      pos_x_q   <= win_d ? ex : '0;
      pos_y_q   <= win_d ? YW'(py_full) : '0;
      pad_top_q <= win_d ? PW'(pad_top_f(int'(py_full), HALF)) : '0;
      pad_bot_q <= win_d ? PW'(pad_bot_f(int'(py_full), HALF, IMG_HEIGHT)) : '0;
      old_q     <= win_d ? eb : '0;
      cur_q     <= win_d ? bus.data_i : '0;
    end
  end

  // Frame FSM; vsync restarts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE; fd_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (start) st_q <= RUN;
      else begin
        case (st_q)
          RUN:     if (run_end) st_q <= FLUSH;
          FLUSH:   if (flush_end) st_q <= DONE;
          DONE:    begin st_q <= IDLE; fd_q <= 1'b1; end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.win_valid   = win_q;
  assign bus.pos_x       = pos_x_q;
  assign bus.pos_y       = pos_y_q;
  assign bus.pad_top     = pad_top_q;
  assign bus.pad_bot     = pad_bot_q;
  assign bus.oldest_bank = old_q;
  assign bus.cur_pix     = cur_q;
  assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_sp_linebuf_sched.sv
// Directed bench for sp_linebuf_sched: NUM=5, 8x6 frame, pixel = row*16+col.
module tb_sp_linebuf_sched;
  localparam int NUM = 5, DD = 12, W = 8, H = 6, HALF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp_linebuf_sched_if #(.NUM(NUM), .DATADEPTH(DD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus();
  sp_linebuf_sched #(.NUM(NUM), .DATADEPTH(DD), .IMG_WIDTH(W), .IMG_HEIGHT(H))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int wv_cnt = 0, fd_cnt = 0;
  bit mon_en = 1'b0;
  bit w_v = 1'b0;
  int w_px = 0, w_py = 0, w_ob = 0, w_cp = -1;
  int PT[6] = '{2, 1, 0, 0, 0, 0};
  int PB[6] = '{0, 0, 0, 0, 1, 2};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pix(input int r, input int c);
    return r * 16 + c;
  endfunction

  // Window checker: each cycle compares against the expectation left by the previous tick.
  always @(negedge clk) begin
    if (bus.win_valid === 1'b1) wv_cnt++;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (mon_en) begin
      chk("win_valid", 32'(bus.win_valid), 32'(w_v));
      if (w_v) begin
        chk("pos_x", 32'(bus.pos_x), w_px);
        chk("pos_y", 32'(bus.pos_y), w_py);
        chk("pad_top", 32'(bus.pad_top), PT[w_py]);
        chk("pad_bot", 32'(bus.pad_bot), PB[w_py]);
        chk("oldest_bank", 32'(bus.oldest_bank), w_ob);
        if (w_cp >= 0) chk("cur_pix", 32'(bus.cur_pix), w_cp);
      end
    end
  end

  task automatic tick(input bit rs, input bit vs, input bit hs, input bit pv, input int d,
                      input bit ce, input int we, input int addr, input int re,
                      input bit wv, input int px, input int py, input int ob, input int cp);
    @(negedge clk);
    rst = rs; bus.vsync = vs; bus.hsync = hs; bus.pix_valid = pv; bus.data_i = DD'(d);
    #1;
    if (ce) begin
      chk("bank_we", 32'(bus.bank_we), we);
      if (addr >= 0) chk("mem_addr", 32'(bus.mem_addr), addr);
      chk("mem_re", 32'(bus.mem_re), re);
      if (pv) chk("mem_wdata", 32'(bus.mem_wdata), d);
    end
    w_v = wv; w_px = px; w_py = py; w_ob = ob; w_cp = cp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic zero_regs(input string t);
    chk({t, ".win_valid"},   32'(bus.win_valid), 0);
    chk({t, ".pos_x"},       32'(bus.pos_x), 0);
    chk({t, ".pos_y"},       32'(bus.pos_y), 0);
    chk({t, ".pad_top"},     32'(bus.pad_top), 0);
    chk({t, ".pad_bot"},     32'(bus.pad_bot), 0);
    chk({t, ".cur_pix"},     32'(bus.cur_pix), 0);
    chk({t, ".oldest_bank"}, 32'(bus.oldest_bank), 0);
    chk({t, ".frame_done"},  32'(bus.frame_done), 0);
    chk({t, ".line_err"},    32'(bus.line_err), 0);
  endtask

  // One frame; optional 50% gaps, one short row, early stop, truncated flush.
  task automatic send_frame(input bit gaps, input int srow, input int slen,
                            input int stop_r, input int stop_c, input int flush_n);
    for (int r = 0; r < H; r++) begin
      int len;
      len = (r == srow) ? slen : W;
      for (int c = 0; c < len; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps && !(r == 0 && c == 0)) tick(0, 0, 0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, -1);
        tick(0, (r == 0 && c == 0), (c == 0), 1, pix(r, c),
             1, 1 << (r % 4), c, 1, (r >= HALF), c, r - HALF, r % 4, pix(r, c));
      end
    end
    for (int i = 0; i < flush_n; i++) begin
      int r, c;
      r = H + i / W; c = i % W;
      tick(0, 0, 0, 0, 0, 1, 0, c, 1, 1, c, r - HALF, r % 4, -1);
    end
  endtask

  initial begin
    rst = 1'b1; bus.vsync = 1'b0; bus.hsync = 1'b0; bus.pix_valid = 1'b0; bus.data_i = '0;
    repeat (2) @(negedge clk);
    tick(1, 0, 0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, -1);
    tick(0, 0, 0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, -1);
    zero_regs("reset");
    mon_en = 1'b1;

    // full frame, no gaps
    wv_cnt = 0; fd_cnt = 0;
    send_frame(0, -1, 0, -1, -1, 16);
    idle(4);
    chk("full.windows", wv_cnt, 48);
    chk("full.frame_done", fd_cnt, 1);
    chk("full.line_err", 32'(bus.line_err), 0);

    // pix_valid at 50%
    wv_cnt = 0; fd_cnt = 0;
    send_frame(1, -1, 0, -1, -1, 16);
    idle(4);
    chk("gaps.windows", wv_cnt, 48);
    chk("gaps.frame_done", fd_cnt, 1);

    // hsync after 5 pixels of row 3
    wv_cnt = 0; fd_cnt = 0;
    send_frame(0, 3, 5, -1, -1, 16);
    idle(4);
    chk("short.windows", wv_cnt, 45);
    chk("short.frame_done", fd_cnt, 1);
    chk("short.line_err", 32'(bus.line_err), 1);
    tick(0, 1, 1, 1, pix(0, 0), 1, 1, 0, 1, 0, 0, 0, 0, -1);
    idle(1);
    chk("vsync.clears_line_err", 32'(bus.line_err), 0);

    // vsync during second flush line
    wv_cnt = 0; fd_cnt = 0;
    send_frame(0, -1, 0, -1, -1, 11);
    tick(0, 1, 1, 1, pix(0, 0), 1, 1, 0, 1, 0, 0, 0, 0, -1);
    idle(20);
    chk("abort.windows", wv_cnt, 43);
    chk("abort.frame_done", fd_cnt, 0);

    // reset pulse at row 2 col 4, then hsync alone in IDLE
    fd_cnt = 0;
    send_frame(0, -1, 0, 2, 4, 0);
    tick(1, 0, 0, 1, pix(2, 4), 0, 0, -1, 0, 0, 0, 0, 0, -1);
    tick(0, 0, 1, 1, pix(2, 5), 1, 0, -1, 0, 0, 0, 0, 0, -1);
    zero_regs("midrst");
    idle(2);
    chk("midrst.frame_done", fd_cnt, 0);
    tick(0, 1, 1, 1, pix(0, 0), 1, 1, 0, 1, 0, 0, 0, 0, -1);
    idle(2);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
